// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a circular transmit buffer.
// A word is popped into the shift register whenever the line is free. Frames go back-to-back.
module uart_tx_param #(
  parameter int unsigned DIVISOR    = 625,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(DIVISOR);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
    $error("uart_tx_param: DIVISOR must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop;

  state_t               state, state_nx;
  logic [BW-1:0]        baud_cnt, baud_nx;
  logic [3:0]           bit_idx, bit_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 par_bit, par_nx;
  logic                 tx_nx;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 wrap;

  assign tx_ready   = (count < CW'(FIFO_DEPTH));
  assign fifo_count = count;
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY == 1) ? ~^head : ^head;
  assign wrap       = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Power-of-2 depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shreg    <= shreg_nx;
      par_bit  <= par_nx;
      tx       <= tx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    par_nx   = par_bit;
    pop      = 1'b0;
    if (state != S_IDLE) baud_nx = wrap ? '0 : baud_cnt + 1'b1;
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          shreg_nx = head;
          par_nx   = head_par;
          baud_nx  = '0;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          state_nx = S_DATA;
          bit_nx   = '0;
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_idx == DATA_LAST) begin
            bit_nx   = '0;
            state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_nx   = bit_idx + 1'b1;
            shreg_nx = shreg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          state_nx = S_STOP;
          bit_nx   = '0;
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (bit_idx != STOP_LAST) begin
            bit_nx = bit_idx + 1'b1;
          end else if (count != '0) begin
            pop      = 1'b1;
            shreg_nx = head;
            par_nx   = head_par;
            bit_nx   = '0;
            state_nx = S_START;
          end else begin
            bit_nx   = '0;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx changes on the same edge as the state.
  always_comb begin
    tx_nx = 1'b1;
    busy  = (state != S_IDLE);
    unique case (state_nx)
      S_IDLE:   tx_nx = 1'b1;
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shreg_nx[0];
      S_PARITY: tx_nx = par_nx;
      S_STOP:   tx_nx = 1'b1;
      default:  tx_nx = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DIVISOR, default 625; clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8; data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4; transmit buffer entries; power of 2, at least 2.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 tx_data  input  DATA_BITS  word to send; sampled only on an accepted handshake.
REQ-009 tx_valid  input  1  producer has a word on tx_data.
REQ-010 tx_ready  output  1  buffer can accept a word.
REQ-011 tx  output  1  serial line; idle high; registered, glitch-free.
REQ-012 busy  output  1  a frame is on the line (state not IDLE).
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  words held in the buffer, excluding the word being shifted.

Function
REQ-014 Accept: a word is written when tx_valid and tx_ready are both high at a rising edge; tx_ready = (fifo_count < FIFO_DEPTH).
REQ-015 Circular buffer: read/write pointers wrap modulo FIFO_DEPTH; a push and a pop in the same cycle leave fifo_count unchanged.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE with fifo_count > 0: pop the head word into the shift register, clear the baud counter, and enter START; tx goes low at that same edge.
REQ-018 Latency: with the buffer empty and state IDLE, tx falls at the first rising edge after the accepting edge.
REQ-019 Each bit is held for exactly DIVISOR clocks; the baud counter counts 0..DIVISOR-1 and wraps; a state advance occurs only at the wrap.
REQ-020 START (tx=0) -> DATA; DATA sends DATA_BITS bits LSB first -> PARITY if PARITY != 0, else STOP.
REQ-021 PARITY bit value: odd mode makes the data-plus-parity ones count odd; even mode makes it even.
REQ-022 STOP holds tx=1 for STOP_BITS*DIVISOR clocks.
REQ-023 End of STOP with fifo_count > 0: pop the next word and enter START directly with zero idle clocks; otherwise enter IDLE.
REQ-024 Frame length is exactly DIVISOR*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) clocks; busy stays high continuously across back-to-back frames.
REQ-025 A push while full is ignored (tx_ready is low); tx_data is not captured; the producer must hold tx_valid.
REQ-026 An illegal parameter value shall stop elaboration with an error.

Reset
REQ-027 While rst is high: tx=1, busy=0, fifo_count=0, tx_ready=1, state IDLE, baud counter and pointers 0.
REQ-028 rst asserted mid-frame: tx returns high immediately (asynchronous); the in-flight frame and all buffered words are discarded.
REQ-029 After rst deasserts, no frame starts until a new word is accepted.

Verification
REQ-030 DIVISOR=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; push 0x44 -> tx sequence 0,0,0,1,0,0,0,1,0,1, each held 4 clocks; busy high for exactly 40 clocks; tx falls 1 clock after acceptance.
REQ-031 Same configuration with PARITY=2, then PARITY=1; push 0x44 -> parity bit 0 (even), then 1 (odd); frame length 44 clocks.
REQ-032 DATA_BITS=7, PARITY=1, STOP_BITS=2, DIVISOR=4; push 0x55 then 0x2A back-to-back -> two frames of 44 clocks each; second start bit immediately follows the 8-clock stop; busy high for 88 continuous clocks.
REQ-033 FIFO_DEPTH=4, tx_valid held high with 6 distinct words from idle -> 5 words accepted on consecutive edges (first popped at once); tx_ready low with fifo_count=4; 6th word accepted on the edge the second word is popped; all 6 words transmitted in order.
REQ-034 rst pulsed during the 3rd data bit with 2 words buffered -> tx=1, busy=0, fifo_count=0 during reset; line stays idle afterwards until a new push.
REQ-035 DIVISOR=2 corner case; push 0x00 and 0xFF -> each bit lasts exactly 2 clocks; no bit is lengthened or shortened at the frame boundary.
